tilelink_sram_slave: RTL and testbench

TileLink-UH memory slave terminating one `slave_*` port of the 1-to-N crossbar. It accepts Get, PutFullData and PutPartialData on channel A, including multi-beat bursts, and stores data in an on-chip synchronous single-port RAM with byte enables. It returns AccessAck or AccessAckData on channel D, and answers out-of-range and unsupported requests with denied responses. It is the first real endpoint the crossbar's burst lock and D-channel arbitration are exercised against.

---
 rtl/tilelink_pkg.sv | 26 ++
 rtl/tilelink_sram_slave_if.sv | 42 ++++
 rtl/tl_sram_bank.sv | 22 ++
 rtl/tilelink_sram_slave.sv | 143 ++++++++++++++
 tb/tb_tilelink_sram_slave.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tilelink_pkg.sv
// Shared TileLink-UH types for the SRAM slave: channel opcodes, FSM encoding and burst math.
package tilelink_pkg;

  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_WRITE = 2'd1;
  localparam state_t S_READ  = 2'd2;
  localparam state_t S_ACK   = 2'd3;

  // Beats in a transfer minus one; lgb is log2 of the bus width in bytes.
  function automatic int unsigned beats_m1(input int unsigned size, input int unsigned lgb);
    return (size <= lgb) ? 32'd0 : (32'd1 << (size - lgb)) - 32'd1;
  endfunction

endpackage

// File: rtl/tilelink_sram_slave_if.sv
// TileLink-UH A/D channel bundle between a crossbar slave port and its endpoint.
interface tilelink_sram_slave_if #(
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4
);
  logic [2:0]         a_opcode;
  logic [2:0]         a_param;
  logic [TL_SZ-1:0]   a_size;
  logic [TL_RS-1:0]   a_source;
  logic [TL_AW-1:0]   a_address;
  logic [TL_DW/8-1:0] a_mask;
  logic [TL_DW-1:0]   a_data;
  logic               a_corrupt;
  logic               a_valid;
  logic               a_ready;

  logic [2:0]         d_opcode;
  logic [1:0]         d_param;
  logic [TL_SZ-1:0]   d_size;
  logic [TL_RS-1:0]   d_source;
  logic               d_denied;
  logic [TL_DW-1:0]   d_data;
  logic               d_corrupt;
  logic               d_valid;
  logic               d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    input  a_ready,
    input  d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
    output d_ready
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    output a_ready,
    output d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
    input  d_ready
  );
endinterface

// File: rtl/tl_sram_bank.sv
// Single-port synchronous SRAM bank with per-byte write enables and a registered read port.
module tl_sram_bank #(
  parameter int TL_DW       = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int NB = TL_DW / 8,
  localparam int IW = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             ren,
  input  logic [NB-1:0]    wen,
  input  logic [IW-1:0]    addr,
  input  logic [TL_DW-1:0] wdata,
  output logic [TL_DW-1:0] rdata
);
  logic [NB-1:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (wen[b]) mem[addr][b] <= wdata[8*b +: 8];
    if (ren) rdata <= mem[addr];
  end
endmodule

// File: rtl/tilelink_sram_slave.sv
// TileLink-UH SRAM endpoint: Get / PutFullData / PutPartialData, denied answers for bad requests.
// Build option TLRAM_BURST_EN: enables multi-beat transfers; otherwise size > bus width is denied.
module tilelink_sram_slave
  import tilelink_pkg::*;
#(
  parameter int               TL_DW       = 32,
  parameter int               TL_AW       = 32,
  parameter int               TL_RS       = 4,
  parameter int               TL_SZ       = 4,
  parameter logic [TL_AW-1:0] BASE_ADDR   = 'h0000_1000,
  parameter int               DEPTH_WORDS = 1024,
  parameter int               MAX_SIZE    = 6
) (
  input logic                  tilelink_clock_i,
  input logic                  tilelink_reset_i,
  tilelink_sram_slave_if.slave slave
);
  localparam int          NB  = TL_DW / 8;
  localparam int unsigned LGB = $clog2(NB);
  localparam int          IW  = $clog2(DEPTH_WORDS);
  localparam int          CW  = 16;
  localparam logic [TL_AW:0] LO = {1'b0, BASE_ADDR};
  localparam logic [TL_AW:0] HI = LO + (TL_AW+1)'(DEPTH_WORDS * NB);

  state_t           state;
  logic [CW-1:0]    cnt, first_m1;
  logic [IW-1:0]    idx, index_now, ram_addr;
  logic [TL_SZ-1:0] sz;
  logic [TL_RS-1:0] src;
  logic             bad, sticky, rd_done, d_valid;
  logic             bad_now, is_put, a_hs, d_hs, ren;
  logic [NB-1:0]    wen;
  logic [TL_DW-1:0] rdata;
  logic             unused_param;

  assign unused_param = ^slave.a_param;
  assign a_hs      = slave.a_valid & slave.a_ready;
  assign d_hs      = d_valid & slave.d_ready;
  assign is_put    = (slave.a_opcode == PUT_FULL_DATA) || (slave.a_opcode == PUT_PARTIAL_DATA);
  assign index_now = IW'((slave.a_address - BASE_ADDR) >> LGB);
  assign first_m1  = CW'(beats_m1(32'(slave.a_size), LGB));

  always_comb begin
    bad_now = !(is_put || slave.a_opcode == GET)
            || ({1'b0, slave.a_address} < LO) || ({1'b0, slave.a_address} >= HI)
            || (int'(slave.a_size) > MAX_SIZE);
`ifndef TLRAM_BURST_EN
    if (int'(slave.a_size) > int'(LGB)) bad_now = 1'b1;
`endif
  end

  // Reads stall whenever a held D beat would be overwritten in the RAM output register.
  assign ren = (state == S_READ) && !rd_done && (!d_valid || slave.d_ready);

  always_comb begin
    wen = '0;
    if (a_hs && !slave.a_corrupt) begin
      if (state == S_IDLE && is_put && !bad_now) wen = slave.a_mask;
      else if (state == S_WRITE && !bad)         wen = slave.a_mask;
    end
  end

  assign ram_addr = (state == S_IDLE) ? index_now : idx;

  tl_sram_bank #(.TL_DW(TL_DW), .DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (tilelink_clock_i),
    .ren   (ren),
    .wen   (wen),
    .addr  (ram_addr),
    .wdata (slave.a_data),
    .rdata (rdata)
  );

  always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
    if (tilelink_reset_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      sz      <= '0;
      src     <= '0;
      bad     <= 1'b0;
      sticky  <= 1'b0;
      rd_done <= 1'b0;
      d_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (a_hs) begin
          sz      <= slave.a_size;
          src     <= slave.a_source;
          bad     <= bad_now;
          sticky  <= is_put & slave.a_corrupt;
          rd_done <= 1'b0;
          cnt     <= first_m1;
          if (slave.a_opcode == GET) begin
            idx   <= index_now;
            state <= S_READ;
          end else if (is_put && first_m1 != '0) begin
            idx   <= index_now + 1'b1;
            state <= S_WRITE;
          end else begin
            state   <= S_ACK;
            d_valid <= 1'b1;
          end
        end
        // cnt holds the beats still owed after the one accepted in IDLE.
        S_WRITE: if (a_hs) begin
          sticky <= sticky | slave.a_corrupt;
          idx    <= idx + 1'b1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= S_ACK;
            d_valid <= 1'b1;
          end
        end
        S_READ: begin
          if (ren) begin
            idx     <= idx + 1'b1;
            d_valid <= 1'b1;
            if (cnt == '0) rd_done <= 1'b1;
            else           cnt     <= cnt - 1'b1;
          end else if (d_hs) begin
            d_valid <= 1'b0;
            if (rd_done) state <= S_IDLE;
          end
        end
        default: if (d_hs) begin
          d_valid <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign slave.a_ready   = (state == S_IDLE) || (state == S_WRITE);
  assign slave.d_valid   = d_valid;
  assign slave.d_opcode  = (state == S_READ) ? ACCESS_ACK_DATA : ACCESS_ACK;
  assign slave.d_param   = 2'b00;
  assign slave.d_size    = sz;
  assign slave.d_source  = src;
  assign slave.d_denied  = bad | sticky;
  assign slave.d_corrupt = (state == S_READ) && bad;
  assign slave.d_data    = (state == S_READ && !bad) ? rdata : '0;
endmodule

// File: tb/tb_tilelink_sram_slave.sv
// Directed bench for tilelink_sram_slave with a word-level memory model and in-order response queue.
`timescale 1ns/1ps
module tb_tilelink_sram_slave;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tilelink_sram_slave_if #(.TL_DW(32), .TL_AW(32), .TL_RS(4), .TL_SZ(4)) bus ();

  tilelink_sram_slave #(
    .TL_DW(32), .TL_AW(32), .TL_RS(4), .TL_SZ(4),
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .MAX_SIZE(6)
  ) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .slave            (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  sz;
    logic [3:0]  src;
    logic        den;
    logic        cor;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mm [int];
  int          total = 0;
  int          nbad = 0;
  int          rd_beats = 0;
  logic [31:0] last_data = '0;
  logic        toggle = 1'b0;
  logic [3:0]  srcn = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  function automatic bit req_bad(logic [2:0] op, logic [3:0] sz, logic [31:0] a);
    bit b;
    b = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || a < BASE || a >= BASE + 32'(4 * DEPTH) || sz > 4'd6;
`ifndef TLRAM_BURST_EN
    if (sz > 4'd2) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic int nbeats(logic [3:0] sz);
    return (sz <= 4'd2) ? 1 : (1 << (int'(sz) - 2));
  endfunction

  function automatic logic [31:0] rd(int wi);
    return mm.exists(wi) ? mm[wi] : 32'h0;
  endfunction

  // Updates the model, queues the expected D beats, then drives the A beats.
  task automatic xfer(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] a,
                      input logic [3:0] mask, input logic [31:0] d0, input logic [31:0] step,
                      input int cbeat);
    bit          b, put, den;
    int          n, w, t, drv;
    logic [31:0] v, dat;
    exp_t        e;
    b   = req_bad(op, sz, a);
    n   = nbeats(sz);
    w   = int'(((a - BASE) >> 2) % 32'(DEPTH));
    put = (op == 3'd0 || op == 3'd1);
    den = b || (put && cbeat >= 0 && cbeat < n);
    srcn++;
    if (put && !b)
      for (int i = 0; i < n; i++)
        if (i != cbeat) begin
          v   = rd((w + i) % DEPTH);
          dat = d0 + step * 32'(i);
          for (int k = 0; k < 4; k++) if (mask[k]) v[8*k +: 8] = dat[8*k +: 8];
          mm[(w + i) % DEPTH] = v;
        end
    if (op == 3'd4) begin
      for (int i = 0; i < n; i++) begin
        e.op = 3'd1; e.sz = sz; e.src = srcn; e.den = b; e.cor = b;
        e.data = b ? 32'h0 : rd((w + i) % DEPTH);
        exp_q.push_back(e);
      end
    end else begin
      e.op = 3'd0; e.sz = sz; e.src = srcn; e.den = den; e.cor = 1'b0; e.data = 32'h0;
      exp_q.push_back(e);
    end
    drv = put ? n : 1;
    for (int i = 0; i < drv; i++) begin
      bus.a_valid   = 1'b1;
      bus.a_opcode  = op;
      bus.a_param   = 3'd0;
      bus.a_size    = sz;
      bus.a_source  = srcn;
      bus.a_address = a + 32'(4 * i);
      bus.a_mask    = mask;
      bus.a_data    = d0 + step * 32'(i);
      bus.a_corrupt = (i == cbeat);
      t = 0;
      while (bus.a_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) begin total++; nbad++; $display("FAIL a_ready_timeout: got 0 want 1"); end
      @(negedge clk);
    end
    bus.a_valid   = 1'b0;
    bus.a_corrupt = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin total++; nbad++; $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    bus.d_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 bus.d_ready = toggle ? !bus.d_ready : 1'b1;
    end
  end

  // Per-cycle compare: D beats against the queue, and held beats must not move.
  initial begin
    logic        hold;
    logic [45:0] snap, cur;
    exp_t        e;
    hold = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) hold = 1'b0;
      else begin
        cur = {bus.d_valid, bus.d_opcode, bus.d_size, bus.d_source, bus.d_denied, bus.d_corrupt, bus.d_data};
        if (hold) chk("d_hold", 64'(cur), 64'(snap));
        if (bus.d_valid && bus.d_ready) begin
          if (exp_q.size() == 0) begin
            total++; nbad++;
            $display("FAIL d_unexpected: got beat op=%0d want none", bus.d_opcode);
          end else begin
            e = exp_q.pop_front();
            chk("d_opcode", 64'(bus.d_opcode), 64'(e.op));
            chk("d_param",  64'(bus.d_param), 64'(0));
            chk("d_size",   64'(bus.d_size), 64'(e.sz));
            chk("d_source", 64'(bus.d_source), 64'(e.src));
            chk("d_denied", 64'(bus.d_denied), 64'(e.den));
            chk("d_corrupt", 64'(bus.d_corrupt), 64'(e.cor));
            if (e.op == 3'd1) begin
              chk("d_data", 64'(bus.d_data), 64'(e.data));
              last_data = bus.d_data;
              rd_beats++;
            end
          end
        end
        hold = bus.d_valid && !bus.d_ready;
        snap = cur;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, t;
    bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
    bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0; bus.a_corrupt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_d_valid", 64'(bus.d_valid), 64'(0));
    chk("rst_a_ready", 64'(bus.a_ready), 64'(1));
    chk("rst_d_data", 64'(bus.d_data), 64'(0));
    chk("rst_d_source", 64'(bus.d_source), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    xfer(3'd0, 4'd2, 32'h1000, 4'hF, 32'hDEADBEEF, 0, -1);
    chk("put_latency", 64'(bus.d_valid), 64'(1));
    drain();
    xfer(3'd4, 4'd2, 32'h1000, 4'hF, 0, 0, -1);
    chk("get_latency_t1", 64'(bus.d_valid), 64'(0));
    @(negedge clk);
    chk("get_latency_t2", 64'(bus.d_valid), 64'(1));
    drain();
    chk("get_deadbeef", 64'(last_data), 64'h0000_0000_DEAD_BEEF);

    xfer(3'd0, 4'd2, 32'h1004, 4'hF, 32'h11223344, 0, -1); drain();
    xfer(3'd1, 4'd2, 32'h1004, 4'b0101, 32'hAABBCCDD, 0, -1); drain();
    xfer(3'd4, 4'd2, 32'h1004, 4'hF, 0, 0, -1); drain();
    chk("partial_merge", 64'(last_data), 64'h0000_0000_11BB_33DD);

    xfer(3'd0, 4'd2, 32'h1FFC, 4'hF, 32'hCAFEF00D, 0, -1); drain();
    xfer(3'd4, 4'd2, 32'h1FFC, 4'hF, 0, 0, -1); drain();
    chk("top_word", 64'(last_data), 64'h0000_0000_CAFE_F00D);

    xfer(3'd0, 4'd6, 32'h1100, 4'hF, 0, 1, -1); drain();
    toggle = 1'b1;
    rd0 = rd_beats;
    xfer(3'd4, 4'd6, 32'h1100, 4'hF, 0, 0, -1); drain();
    toggle = 1'b0;
    chk("burst_beats", 64'(rd_beats - rd0), 64'(16));
`ifdef TLRAM_BURST_EN
    chk("burst_last", 64'(last_data), 64'(15));
`else
    chk("burst_last", 64'(last_data), 64'(0));
`endif

    xfer(3'd4, 4'd2, 32'h0FFC, 4'hF, 0, 0, -1);
    xfer(3'd4, 4'd2, BASE + 32'(4 * DEPTH), 4'hF, 0, 0, -1);
    xfer(3'd4, 4'd2, 32'h1000, 4'hF, 0, 0, -1);
    drain();
    chk("after_oor", 64'(last_data), 64'h0000_0000_DEAD_BEEF);

    xfer(3'd2, 4'd2, 32'h1000, 4'hF, 0, 0, -1); drain();
    xfer(3'd0, 4'd2, 32'h1000, 4'hF, 32'h0, 0, 0); drain();
    xfer(3'd4, 4'd2, 32'h1000, 4'hF, 0, 0, -1); drain();
    chk("corrupt_kept", 64'(last_data), 64'h0000_0000_DEAD_BEEF);

    rd0 = rd_beats;
    xfer(3'd4, 4'd6, 32'h1100, 4'hF, 0, 0, -1);
    t = 0;
    while (rd_beats - rd0 < 5 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin total++; nbad++; $display("FAIL beat5_timeout: got %0d beats want 5", rd_beats - rd0); end
    #2 rst = 1'b1;
    #1;
    chk("midrst_d_valid", 64'(bus.d_valid), 64'(0));
    chk("midrst_a_ready", 64'(bus.a_ready), 64'(1));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(3'd4, 4'd2, 32'h1004, 4'hF, 0, 0, -1); drain();
    chk("post_rst_get", 64'(last_data), 64'h0000_0000_11BB_33DD);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
